// File: rtl/galpal_fuse_loader.sv
// GALPAL fuse loader: accepts ADDR/DATA/END/CLEAR commands to build a JEDEC
// fuse map, then scans the map byte by byte to produce the JEDEC checksum
// and compares it against the value supplied with END.
module galpal_fuse_loader #(
    parameter int FUSES = 5892,
    parameter int BYTES = 737
) (
    input  logic             CLK,
    input  logic             AR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       CMD,
    input  logic [15:0]      DIN,
    output logic [FUSES-1:0] FUSE,
    output logic [15:0]      CHECKSUM,
    output logic             DONE,
    output logic             MATCH,
    output logic             ERR
);

    localparam int              PADW    = BYTES * 8;
    localparam int              BW      = $clog2(BYTES + 1);
    localparam logic [12:0]     FUSES_P = 13'(FUSES);
    localparam logic [13:0]     FUSES_W = 14'(FUSES);
    localparam logic [BW-1:0]   BYTES_B = BW'(BYTES);

    localparam logic [1:0] CMD_ADDR  = 2'b00;
    localparam logic [1:0] CMD_DATA  = 2'b01;
    localparam logic [1:0] CMD_END   = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_SCAN = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               ready_r;
    logic [FUSES-1:0]   fuse_r;
    logic [FUSES-1:0]   fuse_s;
    logic [12:0]        ptr_r;
    logic [12:0]        ptr_s;
    logic               err_r;
    logic               err_s;
    logic [15:0]        expect_r;
    logic [15:0]        acc_r;
    logic [15:0]        checksum_r;
    logic [BW-1:0]      byte_idx_r;
    logic               done_r;
    logic               match_r;

    logic               xfer_s;
    logic               scan_last_s;
    logic [PADW-1:0]    fuse_pad_s;
    logic [7:0]         scan_byte_s;
    logic [15:0]        acc_sum_s;
    logic [13:0]        pos_s;
    logic [13:0]        ptr_adv_s;

    assign xfer_s      = IN_VALID & ready_r;
    // The scan needs one extra cycle after the last byte to publish the result.
    assign scan_last_s = (byte_idx_r == BYTES_B);
    // Bits past the end of the fuse array read as zero in the last byte.
    assign fuse_pad_s  = PADW'(fuse_r);
    assign scan_byte_s = fuse_pad_s[{byte_idx_r, 3'b000} +: 8];
    assign acc_sum_s   = acc_r + {8'h00, scan_byte_s};
    assign ptr_adv_s   = {1'b0, ptr_r} + 14'd8;

    // Next-state decode: any accepted command leaves IDLE/DONE; END starts the scan.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_LOAD, ST_DONE: begin
                if (xfer_s) begin
                    if (CMD == CMD_END) begin
                        state_s = ST_SCAN;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_SCAN: begin
                if (scan_last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and registered ready flag (low only while scanning).
    always_ff @(posedge CLK or posedge AR) begin
        if (AR) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s != ST_SCAN);
        end
    end

    // Command effect on the fuse array, the write pointer and the sticky error.
    always_comb begin
        fuse_s = fuse_r;
        ptr_s  = ptr_r;
        err_s  = err_r;
        pos_s  = 14'd0;
        if (xfer_s) begin
            case (CMD)
                CMD_ADDR: begin
                    if (DIN[12:0] >= FUSES_P) begin
                        err_s = 1'b1;
                    end else begin
                        ptr_s = DIN[12:0];
                    end
                end
                CMD_DATA: begin
                    if (ptr_r >= FUSES_P) begin
                        err_s = 1'b1;
                    end else begin
                        for (int k = 0; k < 8; k++) begin
                            pos_s = {1'b0, ptr_r} + 14'(k);
                            if (pos_s < FUSES_W) begin
                                fuse_s[pos_s[12:0]] = DIN[k];
                            end else begin
                                // past the end of the array: bit is dropped
                                pos_s = FUSES_W;
                            end
                        end
                        // Pointer parks at the array end instead of wrapping.
                        if (ptr_adv_s >= FUSES_W) begin
                            ptr_s = FUSES_P;
                        end else begin
                            ptr_s = ptr_adv_s[12:0];
                        end
                    end
                end
                CMD_CLEAR: begin
                    fuse_s = {FUSES{DIN[0]}};
                end
                default: begin
                    fuse_s = fuse_r;
                end
            endcase
        end else begin
            fuse_s = fuse_r;
        end
    end

    // Fuse array, pointer and sticky error registers; the array powers up blank.
    always_ff @(posedge CLK or posedge AR) begin
        if (AR) begin
            fuse_r <= {FUSES{1'b1}};
            ptr_r  <= 13'd0;
            err_r  <= 1'b0;
        end else begin
            fuse_r <= fuse_s;
            ptr_r  <= ptr_s;
            err_r  <= err_s;
        end
    end

    // Checksum scan: one byte per cycle, result published only when complete.
    always_ff @(posedge CLK or posedge AR) begin
        if (AR) begin
            expect_r   <= 16'h0000;
            acc_r      <= 16'h0000;
            byte_idx_r <= '0;
            checksum_r <= 16'h0000;
            done_r     <= 1'b0;
            match_r    <= 1'b0;
        end else if (xfer_s) begin
            done_r  <= 1'b0;
            match_r <= 1'b0;
            if (CMD == CMD_END) begin
                expect_r   <= DIN;
                acc_r      <= 16'h0000;
                byte_idx_r <= '0;
            end
        end else if (state_r == ST_SCAN) begin
            if (scan_last_s) begin
                checksum_r <= acc_r;
                match_r    <= (acc_r == expect_r);
                done_r     <= 1'b1;
            end else begin
                acc_r      <= acc_sum_s;
                byte_idx_r <= byte_idx_r + BW'(1);
            end
        end
    end

    assign IN_READY = ready_r;
    assign FUSE     = fuse_r;
    assign CHECKSUM = checksum_r;
    assign DONE     = done_r;
    assign MATCH    = match_r;
    assign ERR      = err_r;

endmodule

// File: tb/tb_galpal_fuse_loader.sv
// Self-checking bench for galpal_fuse_loader: directed table, hand-written
// scan/reset corner sequences and randomized commands against a bit-array model.
module tb_galpal_fuse_loader;

    localparam int FUSES = 5892;
    localparam int BYTES = 737;

    localparam logic [1:0] C_ADDR  = 2'b00;
    localparam logic [1:0] C_DATA  = 2'b01;
    localparam logic [1:0] C_END   = 2'b10;
    localparam logic [1:0] C_CLEAR = 2'b11;

    logic             CLK      = 1'b0;
    logic             AR       = 1'b1;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [1:0]       CMD      = 2'b00;
    logic [15:0]      DIN      = 16'h0000;
    logic [FUSES-1:0] FUSE;
    logic [15:0]      CHECKSUM;
    logic             DONE;
    logic             MATCH;
    logic             ERR;

    galpal_fuse_loader #(.FUSES(FUSES), .BYTES(BYTES)) dut (
        .CLK(CLK), .AR(AR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .CMD(CMD), .DIN(DIN), .FUSE(FUSE), .CHECKSUM(CHECKSUM),
        .DONE(DONE), .MATCH(MATCH), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // reference model: plain bit array, unbounded pointer, sticky error
    bit          m_fuse [FUSES];
    int          m_ptr;
    bit          m_err;
    logic [15:0] m_expect;

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] din;
        logic        exp_err;
        int          chk_idx;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_fuse(input string name);
        int nbad  = 0;
        int first = -1;
        for (int i = 0; i < FUSES; i++) begin
            if (FUSE[i] !== m_fuse[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        tests++;
        if (nbad != 0) begin
            fails++;
            $display("FAIL %s: %0d fuse bits differ, first at %0d (got %b, want %b)",
                     name, nbad, first, FUSE[first], m_fuse[first]);
        end
    endtask

    // JEDEC checksum: sum of all bytes, missing bits read as 0, modulo 2^16
    function automatic logic [15:0] model_checksum();
        int unsigned s = 0;
        for (int b = 0; b < BYTES; b++)
            for (int k = 0; k < 8; k++)
                if ((8 * b + k) < FUSES && m_fuse[8 * b + k]) s += (32'd1 << k);
        return 16'(s % 65536);
    endfunction

    task automatic model_reset();
        foreach (m_fuse[i]) m_fuse[i] = 1'b1;
        m_ptr    = 0;
        m_err    = 1'b0;
        m_expect = 16'h0000;
    endtask

    task automatic model_cmd(input logic [1:0] c, input logic [15:0] d);
        int a;
        case (c)
            C_ADDR: begin
                a = int'(d[12:0]);
                if (a >= FUSES) m_err = 1'b1;
                else m_ptr = a;
            end
            C_DATA: begin
                if (m_ptr >= FUSES) m_err = 1'b1;
                else begin
                    for (int k = 0; k < 8; k++)
                        if (m_ptr + k < FUSES) m_fuse[m_ptr + k] = d[k];
                    m_ptr = m_ptr + 8;
                end
            end
            C_CLEAR: foreach (m_fuse[i]) m_fuse[i] = d[0];
            default: m_expect = d;
        endcase
    endtask

    // reset asserted just after an edge, released just after the next edge
    task automatic apply_reset();
        AR = 1'b1;
        IN_VALID = 1'b0;
        #2;
        model_reset();
        @(posedge CLK); #1;
        AR = 1'b0;
    endtask

    task automatic send(input logic [1:0] c, input logic [15:0] d);
        chk("ready_before_xfer", 32'(IN_READY), 32'd1);
        IN_VALID = 1'b1;
        CMD = c;
        DIN = d;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        model_cmd(c, d);
    endtask

    // called just after the END acceptance edge; leaves inputs untouched
    task automatic wait_done(input string name);
        int n = 0;
        bit rdy_bad = 1'b0;
        if (IN_READY !== 1'b0) rdy_bad = 1'b1;
        while (n < BYTES + 20) begin
            @(posedge CLK); #1;
            n++;
            if (DONE === 1'b1) break;
            if (IN_READY !== 1'b0) rdy_bad = 1'b1;
        end
        chk({name, "_done_edge"}, 32'(n), 32'(BYTES + 1));
        chk({name, "_ready_low"}, 32'(rdy_bad), 32'd0);
        chk({name, "_ready_after"}, 32'(IN_READY), 32'd1);
    endtask

    task automatic check_result(input string name);
        logic [15:0] cs;
        cs = model_checksum();
        chk({name, "_checksum"}, 32'(CHECKSUM), 32'(cs));
        chk({name, "_match"}, 32'(MATCH), 32'(cs == m_expect));
        chk({name, "_err"}, 32'(ERR), 32'(m_err));
    endtask

    initial begin
        logic [12:0] a13;
        logic [15:0] d;
        logic [7:0]  got;
        int          op;

        vt[0]  = '{C_CLEAR, 16'h0000, 1'b0, 0,    8'h00};
        vt[1]  = '{C_ADDR,  16'h0000, 1'b0, 0,    8'h00};
        vt[2]  = '{C_DATA,  16'h12A5, 1'b0, 0,    8'hA5};
        vt[3]  = '{C_DATA,  16'h003C, 1'b0, 8,    8'h3C};
        vt[4]  = '{C_ADDR,  16'h0003, 1'b0, 0,    8'hA5};
        vt[5]  = '{C_DATA,  16'h00FF, 1'b0, 0,    8'hFD};
        vt[6]  = '{C_ADDR,  16'd5888, 1'b0, 5884, 8'h00};
        vt[7]  = '{C_DATA,  16'h00FF, 1'b0, 5884, 8'hF0};
        vt[8]  = '{C_DATA,  16'h0000, 1'b1, 5884, 8'hF0};
        vt[9]  = '{C_ADDR,  16'h0000, 1'b1, 0,    8'hFD};
        vt[10] = '{C_CLEAR, 16'h0001, 1'b1, 5884, 8'hFF};
        vt[11] = '{C_ADDR,  16'd6000, 1'b1, 0,    8'hFF};
        vt[12] = '{C_DATA,  16'h0000, 1'b1, 0,    8'h00};

        // reset values
        apply_reset();
        chk("rst_ready", 32'(IN_READY), 32'd1);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_match", 32'(MATCH), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_checksum", 32'(CHECKSUM), 32'h0000);
        chk("rst_fuse_blank", 32'(&FUSE), 32'd1);

        // blank-array checksum
        send(C_END, 16'hDD2F);
        chk("blank_done_cleared", 32'(DONE), 32'd0);
        wait_done("blank");
        chk("blank_checksum_const", 32'(CHECKSUM), 32'hDD2F);
        chk("blank_match_const", 32'(MATCH), 32'd1);
        check_result("blank");

        // single programmed byte, then a mismatching END
        send(C_CLEAR, 16'h0000);
        chk("xfer_in_done_clears_done", 32'(DONE), 32'd0);
        chk("xfer_in_done_clears_match", 32'(MATCH), 32'd0);
        send(C_ADDR, 16'h0000);
        send(C_DATA, 16'h00A5);
        send(C_END, 16'h00A5);
        wait_done("a5");
        chk("a5_byte0", 32'(FUSE[7:0]), 32'hA5);
        chk("a5_rest_zero", 32'(|FUSE[FUSES-1:8]), 32'd0);
        chk("a5_checksum_const", 32'(CHECKSUM), 32'h00A5);
        chk("a5_match_const", 32'(MATCH), 32'd1);
        chk_fuse("a5_fuse");
        send(C_END, 16'h0000);
        wait_done("a5_bad");
        chk("a5_bad_match", 32'(MATCH), 32'd0);
        chk("a5_bad_checksum", 32'(CHECKSUM), 32'h00A5);

        // reset in the middle of a scan
        send(C_END, 16'h1234);
        repeat (300) begin @(posedge CLK); #1; end
        chk("midscan_no_partial", 32'(CHECKSUM), 32'h00A5);
        chk("midscan_ready", 32'(IN_READY), 32'd0);
        AR = 1'b1;
        #2;
        model_reset();
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_checksum", 32'(CHECKSUM), 32'h0000);
        chk("abort_ready", 32'(IN_READY), 32'd1);
        chk_fuse("abort_fuse_blank");
        @(posedge CLK); #1;
        AR = 1'b0;
        send(C_END, 16'hDD2F);
        wait_done("after_abort");
        chk("after_abort_checksum", 32'(CHECKSUM), 32'hDD2F);
        check_result("after_abort");

        // directed table: pointer, drop-past-end, saturation and sticky error
        apply_reset();
        for (int i = 0; i < 13; i++) begin
            send(vt[i].cmd, vt[i].din);
            got = FUSE[vt[i].chk_idx +: 8];
            chk($sformatf("vec%0d_err", i), 32'(ERR), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_byte", i), 32'(got), 32'(vt[i].exp_byte));
            chk_fuse($sformatf("vec%0d_fuse", i));
        end
        send(C_END, 16'hDC30);
        wait_done("vec_end");
        chk("vec_end_checksum", 32'(CHECKSUM), 32'hDC30);
        chk("vec_end_match", 32'(MATCH), 32'd1);
        chk("vec_end_err_kept", 32'(ERR), 32'd1);

        // DATA held valid through a scan: ignored until DONE, then accepted once
        apply_reset();
        send(C_END, 16'hDD2F);
        IN_VALID = 1'b1;
        CMD = C_DATA;
        DIN = 16'h0000;
        wait_done("held");
        chk("held_checksum", 32'(CHECKSUM), 32'hDD2F);
        check_result("held");
        chk_fuse("held_fuse_untouched");
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        model_cmd(C_DATA, 16'h0000);
        chk("held_accept_clears_done", 32'(DONE), 32'd0);
        chk("held_byte0", 32'(FUSE[7:0]), 32'h00);
        chk_fuse("held_fuse_written");

        // randomized commands against the model
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            for (int i = 0; i < 100; i++) begin
                op = int'($urandom_range(0, 99));
                d  = 16'($urandom);
                if (op < 35) begin
                    case ($urandom_range(0, 3))
                        0: a13 = 13'($urandom_range(0, FUSES - 1));
                        1: a13 = 13'(FUSES - 12 + int'($urandom_range(0, 23)));
                        2: a13 = 13'($urandom);
                        default: a13 = 13'd0;
                    endcase
                    d[12:0] = a13;
                    send(C_ADDR, d);
                end else if (op < 92) begin
                    send(C_DATA, d);
                end else if (op < 97) begin
                    send(C_CLEAR, d);
                end else begin
                    if ($urandom_range(0, 1) == 1) d = model_checksum();
                    send(C_END, d);
                    wait_done($sformatf("rnd%0d_%0d", r, i));
                    check_result($sformatf("rnd%0d_%0d", r, i));
                end
                chk($sformatf("rnd%0d_%0d_err", r, i), 32'(ERR), 32'(m_err));
                chk_fuse($sformatf("rnd%0d_%0d_fuse", r, i));
            end
            send(C_END, model_checksum());
            wait_done($sformatf("rnd%0d_final", r));
            check_result($sformatf("rnd%0d_final", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
